// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths, framing constants and FSM state type for the
// boot-time program loader. Build macro PROG_LOADER_CHECKSUM_EN adds the CHK state.
package prog_loader_pkg;

    localparam int         PL_ADDR_W      = 12;
    localparam int         PL_DATA_W      = 16;
    localparam int         PL_MAX_WORDS   = 4096;
    localparam logic [7:0] PL_SYNC_BYTE   = 8'hA5;
    localparam int         PL_TIMEOUT_CYC = 65535;
    localparam int         PL_CNT_W       = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_WORD_HI,
        ST_WORD_LO,
        ST_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle counter for the program loader. Counts while armed,
// restarts on clear or when disarmed, and raises expire once LIMIT idle cycles pass.
module loader_timeout
    import prog_loader_pkg::*;
#(
    parameter int LIMIT = PL_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] idle_cnt;

    assign expire = (idle_cnt == W'(LIMIT));

    // Count idle cycles while armed, saturating at the limit; any accepted byte or disarm restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!run || clear) begin
            idle_cnt <= '0;
        end else if (!expire) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: assembles a framed byte stream (SYNC, count hi/lo, word hi/lo ...)
// into 16-bit instruction words, writes them into the CPU instruction memory and
// releases the CPU once the image is complete.
// Build macro PROG_LOADER_CHECKSUM_EN: adds a trailing XOR checksum byte (CHK state).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W      = PL_ADDR_W,
    parameter int         DATA_W      = PL_DATA_W,
    parameter int         MAX_WORDS   = PL_MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE   = PL_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = PL_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              we_im,
    output logic [DATA_W-1:0] code_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = PL_CNT_W;

    state_t             state;
    logic               xfer;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [ADDR_W:0]    addr;
    logic [ADDR_W:0]    addr_next;
    logic               last_word;
    logic [7:0]         code_hi;
    logic               timer_run;
    logic               timer_expire;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    assign xfer      = byte_valid & byte_ready;
    assign cnt_next  = {word_cnt[CNT_W-1:8], byte_in};
    assign addr_next = addr + 1'b1;
    assign last_word = ({{(CNT_W-ADDR_W-1){1'b0}}, addr_next} == word_cnt);

    // Arm the idle timer only in states that are waiting for the next byte of a frame
    always_comb begin
        timer_run = 1'b0;
        case (state)
            ST_CNT_HI, ST_CNT_LO, ST_WORD_HI, ST_WORD_LO: timer_run = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: timer_run = 1'b1;
`endif
            default: timer_run = 1'b0;
        endcase
    end

    loader_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .clear  (xfer),
        .expire (timer_expire)
    );

    // Frame FSM with registered status/handshake outputs and the memory write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b1;
            we_im      <= 1'b0;
            code_out   <= '0;
            addr_out   <= '0;
            cpu_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
            addr       <= '0;
            code_hi    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            we_im      <= 1'b0;
            byte_ready <= 1'b1;
            if (timer_expire) begin
                state  <= ST_ERR;
                busy   <= 1'b0;
                err    <= 1'b1;
                cpu_en <= 1'b0;
                done   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_RUN, ST_ERR: begin
                        if (xfer && byte_in == SYNC_BYTE) begin
                            state  <= ST_CNT_HI;
                            busy   <= 1'b1;
                            cpu_en <= 1'b0;
                            done   <= 1'b0;
                            err    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum   <= '0;
`endif
                        end
                    end
                    ST_CNT_HI: begin
                        if (xfer) begin
                            word_cnt[CNT_W-1:8] <= byte_in;
                            state               <= ST_CNT_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum                <= csum ^ byte_in;
`endif
                        end
                    end
                    ST_CNT_LO: begin
                        if (xfer) begin
                            word_cnt <= cnt_next;
                            addr     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum     <= csum ^ byte_in;
`endif
                            if (cnt_next == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                state  <= ST_CHK;
`else
                                state  <= ST_RUN;
                                busy   <= 1'b0;
                                cpu_en <= 1'b1;
                                done   <= 1'b1;
`endif
                            end else if (cnt_next > CNT_W'(MAX_WORDS)) begin
                                state <= ST_ERR;
                                busy  <= 1'b0;
                                err   <= 1'b1;
                            end else begin
                                state <= ST_WORD_HI;
                            end
                        end
                    end
                    ST_WORD_HI: begin
                        if (xfer) begin
                            code_hi <= byte_in;
                            state   <= ST_WORD_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum    <= csum ^ byte_in;
`endif
                        end
                    end
                    ST_WORD_LO: begin
                        if (xfer) begin
                            code_out   <= {code_hi, byte_in};
                            addr_out   <= addr[ADDR_W-1:0];
                            we_im      <= 1'b1;
                            byte_ready <= 1'b0;
                            state      <= ST_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum       <= csum ^ byte_in;
`endif
                        end
                    end
                    ST_WRITE: begin
                        addr <= addr_next;
                        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state  <= ST_CHK;
`else
                            state  <= ST_RUN;
                            busy   <= 1'b0;
                            cpu_en <= 1'b1;
                            done   <= 1'b1;
`endif
                        end else begin
                            state <= ST_WORD_HI;
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (xfer) begin
                            busy <= 1'b0;
                            if (byte_in == csum) begin
                                state  <= ST_RUN;
                                cpu_en <= 1'b1;
                                done   <= 1'b1;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
